// File: rtl/gcm_pkg.sv
// gcm_pkg -- shared definitions for the GCM counter-block generator.
//   state_e        : control FSM encoding (IDLE / ISSUE / DONE)
//   J0_LSW         : low word appended to a 96-bit IV to form J0
//   MAX_PT_BLOCKS  : largest plaintext block count a message may carry
//   inc32()        : GCM counter increment (low 32 bits only, no carry out)
//   clamp_pt()     : saturate a requested block count to MAX_PT_BLOCKS
package gcm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic [31:0] J0_LSW        = 32'h0000_0001;
   localparam logic [4:0]  MAX_PT_BLOCKS = 5'd30;

   // Upper 96 bits pass through; the low word wraps on its own.
   function automatic logic [127:0] inc32(input logic [127:0] x);
      return {x[127:32], x[31:0] + 32'd1};
   endfunction

   function automatic logic [4:0] clamp_pt(input logic [4:0] b);
      return (b > MAX_PT_BLOCKS) ? MAX_PT_BLOCKS : b;
   endfunction

endpackage

// File: rtl/gcm_ctr_gen.sv
// gcm_ctr_gen -- issues the GCM counter sequence J0, inc32(J0) .. inc32^n(J0)
// to the AES data input, one block per cycle with no gaps.
//   clk, rst          : clock, synchronous active-high reset
//   req_i             : start of message, only looked at while idle
//   iv_mode_i         : 0 = 96-bit IV on iv_in_i[127:32], 1 = iv_in_i is J0
//   iv_in_i           : IV or precomputed J0
//   pt_blocks_i       : plaintext block count (saturated at 30)
//   aad_blocks_i      : AAD block count, echoed on aad_total_o
//   ctr_block_o       : counter block, zero whenever ctr_valid_o is low
//   ctr_valid_o       : ctr_block_o is valid
//   aes_start_o       : single pulse alongside J0
//   data_total_o      : blocks issued for the message, J0 included
//   aad_total_o       : registered aad_blocks_i
//   busy_o            : message in flight (ISSUE and DONE)
//   done_o            : single pulse after the last counter block
// Every output is a flop; the accept edge loads J0 straight into the
// output register so the first ISSUE cycle already presents it.
module gcm_ctr_gen
   import gcm_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         req_i,
   input  logic         iv_mode_i,
   input  logic [127:0] iv_in_i,
   input  logic [4:0]   pt_blocks_i,
   input  logic [4:0]   aad_blocks_i,
   output logic [127:0] ctr_block_o,
   output logic         ctr_valid_o,
   output logic         aes_start_o,
   output logic [31:0]  data_total_o,
   output logic [31:0]  aad_total_o,
   output logic         busy_o,
   output logic         done_o
);

   state_e         state_q, state_d;
   logic [127:0]   ctr_q, ctr_d;
   logic           valid_q, valid_d;
   logic           start_q, start_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;
   logic [4:0]     idx_q, idx_d;   // index k of the block currently presented
   logic [4:0]     n_q, n_d;       // last index to present
   logic [31:0]    dtot_q, dtot_d;
   logic [31:0]    atot_q, atot_d;
   logic [4:0]     n_clamped;

   assign n_clamped = clamp_pt(pt_blocks_i);

   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      valid_d = valid_q;
      start_d = 1'b0;
      done_d  = 1'b0;
      busy_d  = busy_q;
      idx_d   = idx_q;
      n_d     = n_q;
      dtot_d  = dtot_q;
      atot_d  = atot_q;
      case (state_q)
         ST_IDLE: begin
            busy_d  = 1'b0;
            valid_d = 1'b0;
            ctr_d   = '0;
            if (req_i) begin
               state_d = ST_ISSUE;
               ctr_d   = iv_mode_i ? iv_in_i : {iv_in_i[127:32], J0_LSW};
               valid_d = 1'b1;
               start_d = 1'b1;
               busy_d  = 1'b1;
               idx_d   = '0;
               n_d     = n_clamped;
               dtot_d  = {27'd0, n_clamped} + 32'd1;
               atot_d  = {27'd0, aad_blocks_i};
            end
         end
         ST_ISSUE: begin
            if (idx_q == n_q) begin
               state_d = ST_DONE;
               valid_d = 1'b0;
               ctr_d   = '0;
               done_d  = 1'b1;
            end else begin
               ctr_d = inc32(ctr_q);
               idx_d = idx_q + 5'd1;
            end
         end
         ST_DONE: begin
            // req is ignored here; busy drops as we re-enter IDLE
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            ctr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ctr_q   <= '0;
         valid_q <= 1'b0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         idx_q   <= '0;
         n_q     <= '0;
         dtot_q  <= '0;
         atot_q  <= '0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         valid_q <= valid_d;
         start_q <= start_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         idx_q   <= idx_d;
         n_q     <= n_d;
         dtot_q  <= dtot_d;
         atot_q  <= atot_d;
      end
   end

   assign ctr_block_o  = ctr_q;
   assign ctr_valid_o  = valid_q;
   assign aes_start_o  = start_q;
   assign data_total_o = dtot_q;
   assign aad_total_o  = atot_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_gcm_ctr_gen.sv
// tb_gcm_ctr_gen -- directed bench for gcm_ctr_gen. Inputs change and
// outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_gcm_ctr_gen;

   logic         clk = 1'b0;
   logic         rst;
   logic         req;
   logic         iv_mode;
   logic [127:0] iv_in;
   logic [4:0]   pt_blocks;
   logic [4:0]   aad_blocks;
   logic [127:0] ctr_block;
   logic         ctr_valid;
   logic         aes_start;
   logic [31:0]  data_total;
   logic [31:0]  aad_total;
   logic         busy;
   logic         done;

   int vectors     = 0;
   int miscompares = 0;

   gcm_ctr_gen dut (
      .clk          (clk),
      .rst          (rst),
      .req_i        (req),
      .iv_mode_i    (iv_mode),
      .iv_in_i      (iv_in),
      .pt_blocks_i  (pt_blocks),
      .aad_blocks_i (aad_blocks),
      .ctr_block_o  (ctr_block),
      .ctr_valid_o  (ctr_valid),
      .aes_start_o  (aes_start),
      .data_total_o (data_total),
      .aad_total_o  (aad_total),
      .busy_o       (busy),
      .done_o       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".valid"}, 128'(ctr_valid), 128'(1'b0));
      chk({tag, ".block"}, ctr_block, 128'd0);
      chk({tag, ".start"}, 128'(aes_start), 128'(1'b0));
      chk({tag, ".busy"},  128'(busy), 128'(1'b0));
      chk({tag, ".done"},  128'(done), 128'(1'b0));
   endtask

   // Apply a request in the current (idle) cycle; returns on the first ISSUE cycle.
   task automatic start(input logic mode, input logic [127:0] iv,
                        input logic [4:0] pt, input logic [4:0] aad);
      iv_mode = mode; iv_in = iv; pt_blocks = pt; aad_blocks = aad; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
   endtask

   // Check cnt valid cycles starting at j0, the DONE cycle and the IDLE
   // cycle after it. If poke >= 0, pulse req with a different IV/count at
   // ISSUE cycle poke; it must be ignored.
   task automatic check_msg(input string tag, input logic [127:0] j0, input int cnt,
                            input logic [31:0] dt, input logic [31:0] at, input int poke);
      for (int k = 0; k < cnt; k++) begin
         chk({tag, ".valid"}, 128'(ctr_valid), 128'(1'b1));
         chk({tag, ".block"}, ctr_block, {j0[127:32], j0[31:0] + 32'(k)});
         chk({tag, ".start"}, 128'(aes_start), 128'(k == 0));
         chk({tag, ".busy"},  128'(busy), 128'(1'b1));
         chk({tag, ".done"},  128'(done), 128'(1'b0));
         chk({tag, ".dtot"},  128'(data_total), 128'(dt));
         chk({tag, ".atot"},  128'(aad_total), 128'(at));
         if (k == poke) begin
            req = 1'b1; iv_in = ~iv_in; iv_mode = ~iv_mode;
            pt_blocks = 5'd7; aad_blocks = 5'd9;
         end else begin
            req = 1'b0;
         end
         @(negedge clk);
      end
      req = 1'b0;
      chk({tag, ".d_valid"}, 128'(ctr_valid), 128'(1'b0));
      chk({tag, ".d_block"}, ctr_block, 128'd0);
      chk({tag, ".d_done"},  128'(done), 128'(1'b1));
      chk({tag, ".d_busy"},  128'(busy), 128'(1'b1));
      @(negedge clk);
      chk_idle({tag, ".idle"});
      chk({tag, ".hold_dtot"}, 128'(data_total), 128'(dt));
      chk({tag, ".hold_atot"}, 128'(aad_total), 128'(at));
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; iv_mode = 1'b0; iv_in = '0;
      pt_blocks = '0; aad_blocks = '0;
      repeat (2) @(negedge clk);
      chk_idle("reset");
      chk("reset.dtot", 128'(data_total), 128'd0);
      chk("reset.atot", 128'(aad_total), 128'd0);

      // reset wins over a simultaneous request
      req = 1'b1; pt_blocks = 5'd3;
      @(negedge clk);
      req = 1'b0; rst = 1'b0;
      chk_idle("rst_prio");
      @(negedge clk);
      chk_idle("rst_prio2");

      // 96-bit IV, low word of iv_in ignored
      start(1'b0, {96'hCAFEBABEFACEDBADDECAF888, 32'hDEADBEEF}, 5'd3, 5'd2);
      check_msg("iv96", {96'hCAFEBABEFACEDBADDECAF888, 32'h1}, 4, 32'd4, 32'd2, -1);

      // back-to-back: request on the very first idle cycle; J0 wraps low word
      start(1'b1, {96'h0123456789ABCDEF00112233, 32'hFFFFFFFE}, 5'd2, 5'd31);
      check_msg("wrap", {96'h0123456789ABCDEF00112233, 32'hFFFFFFFE}, 3, 32'd3, 32'd31, -1);

      // zero plaintext blocks: J0 only
      @(negedge clk);
      start(1'b0, {96'h111122223333444455556666, 32'h0}, 5'd0, 5'd0);
      check_msg("pt0", {96'h111122223333444455556666, 32'h1}, 1, 32'd1, 32'd0, -1);

      // 31 requested blocks clamp to 30
      start(1'b1, {96'hA5A5A5A5A5A5A5A5A5A5A5A5, 32'h7FFFFFF0}, 5'd31, 5'd4);
      check_msg("clamp", {96'hA5A5A5A5A5A5A5A5A5A5A5A5, 32'h7FFFFFF0}, 31, 32'd31, 32'd4, -1);

      // req during ISSUE is ignored
      start(1'b1, {96'h0F0E0D0C0B0A090807060504, 32'h00000010}, 5'd4, 5'd6);
      check_msg("ignore", {96'h0F0E0D0C0B0A090807060504, 32'h00000010}, 5, 32'd5, 32'd6, 1);

      // reset on the 3rd ISSUE cycle aborts the message
      start(1'b0, {96'hFEEDFACE0123456789ABCDEF, 32'h0}, 5'd8, 5'd3);
      chk("abort.c0", ctr_block, {96'hFEEDFACE0123456789ABCDEF, 32'h1});
      @(negedge clk);
      chk("abort.c1", ctr_block, {96'hFEEDFACE0123456789ABCDEF, 32'h2});
      @(negedge clk);
      chk("abort.c2", ctr_block, {96'hFEEDFACE0123456789ABCDEF, 32'h3});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_idle("abort");
      chk("abort.dtot", 128'(data_total), 128'd0);
      chk("abort.atot", 128'(aad_total), 128'd0);
      repeat (3) begin
         @(negedge clk);
         chk_idle("abort.noresume");
      end
      start(1'b0, {96'h00000000000000000000BEEF, 32'hFFFFFFFF}, 5'd1, 5'd1);
      check_msg("restart", {96'h00000000000000000000BEEF, 32'h1}, 2, 32'd2, 32'd1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
